matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Parametrised control FSM that sequences a full M x N x K matrix multiply through a pipelined MAC datapath.
- Generates operand addresses, load/mult/acc strobes, accumulator clear and per-element writeback with a valid/ready handshake.
- Issues one inner-product term per cycle instead of one per three cycles.
- Sits between the host command interface and the MAC array / operand memories.

Parameters:
- DIM_MAX, 8, largest legal value of each of M, N, K.
- DW, $clog2(DIM_MAX+1), width of the dimension inputs and of the wb_row/wb_col outputs.
- AW, $clog2(DIM_MAX*DIM_MAX), operand address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  command strobe, sampled only in IDLE.
- m_dim  in  DW  rows of A, latched on accepted start.
- n_dim  in  DW  columns of B, latched on accepted start.
- k_dim  in  DW  inner dimension, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- a_addr  out  AW  A read address = i*K + kk, valid when load_en=1.
- b_addr  out  AW  B read address = kk*N + j, valid when load_en=1.
- load_en  out  1  operand load strobe.
- mult_en  out  1  multiply strobe.
- acc_en  out  1  accumulate strobe.
- acc_clr  out  1  clear accumulator; high with the first load_en of each output element.
- wb_valid  out  1  accumulator result for (wb_row, wb_col) ready.
- wb_ready  in  1  consumer accepts the writeback.
- wb_row  out  DW  row index i of the element being written back.
- wb_col  out  DW  column index j of the element being written back.
- done  out  1  one-cycle completion pulse.
- err  out  1  high together with done when the command was illegal.
- cycle_count  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset wins over every other event, including mid-operation; no partial writeback and no done pulse.
- States: IDLE, RUN, DRAIN, WB, FIN.
- IDLE:
  - start=1 with all dims in 1..DIM_MAX: latch dims, set i=j=kk=0, go to RUN.
  - start=1 with any dim equal to 0 or >DIM_MAX: go to FIN with the err flag set; no strobes are issued.
- RUN:
  - load_en=1 every cycle; kk counts 0..K-1; acc_clr=1 when kk=0.
  - After kk=K-1, go to DRAIN.
- Strobe pipeline: mult_en is load_en delayed 1 cycle; acc_en is load_en delayed 2 cycles. Implemented as a shift pipeline, independent of state.
- DRAIN: exactly 2 cycles, waiting for the last acc_en; then go to WB.
- WB:
  - wb_valid=1; wb_row/wb_col hold i/j stable until wb_ready=1.
  - On acceptance: advance j, wrapping to 0 and incrementing i at N-1.
  - If the element just accepted was (M-1, N-1), go to FIN; otherwise return to RUN with kk=0 in the next cycle.
- FIN: done=1 and err=flag for one cycle, then go to IDLE.
- Cost per element: K+3 cycles with wb_ready held high; each cycle of wb_ready=0 adds one cycle.
- Timing with start sampled in cycle 0:
  - first load_en in cycle 1.
  - last acc_en of an element in cycle K+2.
  - wb_valid in cycle K+3.
- start is ignored while busy. m_dim/n_dim/k_dim changes during an operation have no effect.
- Addresses are built with incremental adders (a_addr += 1 per term; b_addr += N per term; row base += K per row), not multipliers.
- Addresses fit AW bits for all legal dims.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - cycle_count clears to 0 on an accepted start and increments each cycle while busy=1.
  - It holds its value after done until the next accepted start.
  - It counts writeback stall cycles.
  - It is 0 on reset.
- Undefined: cycle_count is constant 0 and no counter logic is inferred.

Test Plan:
- M=N=K=1, wb_ready=1, start in cycle 0:
  - load_en+acc_clr in cycle 1, mult_en in cycle 2, acc_en in cycle 3.
  - wb_valid with row=0, col=0 in cycle 4; done in cycle 5; err=0.
- M=N=K=2, wb_ready=1:
  - writebacks in order (0,0),(0,1),(1,0),(1,1) at cycles 5, 10, 15, 20; done in cycle 21.
  - a_addr sequence 0,1 / 0,1 / 2,3 / 2,3; b_addr sequence 0,2 / 1,3 / 0,2 / 1,3.
  - With PERF_CNT_EN, cycle_count=21 after done.
- M=1, N=1, K=4 with wb_ready=0 for 3 cycles after wb_valid rises: wb_valid held 4 cycles; wb_row/wb_col stable; done 1 cycle after acceptance.
- k_dim=0, or m_dim=DIM_MAX+1: done=1 and err=1 in cycle 1; no load_en, mult_en or acc_en ever asserted.
- Assert reset during RUN of a 3x3x3 command: all outputs 0 at the next edge. Then start a 1x1x1 command: it completes normally with done in cycle 5.
- Pulse start again while busy: no effect; the writeback count equals M*N of the first command only.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Control FSM sequencing an M x N x K matrix multiply through a pipelined MAC, one term per cycle.
// Build with PERF_CNT_EN defined to enable the busy-cycle counter on cycle_count.
module matmul_sequencer #(
   parameter int DIM_MAX = 8,
   parameter int DW      = $clog2(DIM_MAX + 1),
   parameter int AW      = $clog2(DIM_MAX * DIM_MAX)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] m_dim,
   input  logic [DW-1:0] n_dim,
   input  logic [DW-1:0] k_dim,
   output logic          busy,
   output logic [AW-1:0] a_addr,
   output logic [AW-1:0] b_addr,
   output logic          load_en,
   output logic          mult_en,
   output logic          acc_en,
   output logic          acc_clr,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [DW-1:0] wb_row,
   output logic [DW-1:0] wb_col,
   output logic          done,
   output logic          err,
   output logic [31:0]   cycle_count
);
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, WB, FIN} state_t;

   localparam logic [DW-1:0] DMAX = DW'(DIM_MAX);
   localparam logic [DW-1:0] ONE  = DW'(1);
   localparam logic [AW-1:0] AONE = AW'(1);

   state_t        state_q, state_d;
   logic [DW-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
   logic [DW-1:0] i_q, i_d, j_q, j_d, kk_q, kk_d;
   logic [AW-1:0] a_q, a_d, b_q, b_d, row_q, row_d;
   logic          err_q, err_d, drain_q, drain_d;
   logic          mult_q, acc_q;
   logic          dims_ok, last_k, last_j, last_elem;

   assign dims_ok   = (m_dim != '0) && (m_dim <= DMAX) &&
                      (n_dim != '0) && (n_dim <= DMAX) &&
                      (k_dim != '0) && (k_dim <= DMAX);
   assign last_k    = (kk_q == k_q - ONE);
   assign last_j    = (j_q == n_q - ONE);
   assign last_elem = last_j && (i_q == m_q - ONE);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = dims_ok ? RUN : FIN;
         RUN:     if (last_k) state_d = DRAIN;
         DRAIN:   if (drain_q) state_d = WB;
         WB:      if (wb_ready) state_d = last_elem ? FIN : RUN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      load_en  = 1'b0;
      wb_valid = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state_q)
         RUN:     begin busy = 1'b1; load_en = 1'b1; end
         DRAIN:   busy = 1'b1;
         WB:      begin busy = 1'b1; wb_valid = 1'b1; end
         FIN:     begin busy = 1'b1; done = 1'b1; err = err_q; end
         default: busy = 1'b0;
      endcase
      acc_clr = load_en && (kk_q == '0);
   end

   // Addresses advance by addition only: a by 1, b by N per term; row base by K per row.
   always_comb begin
      m_d     = m_q;
      n_d     = n_q;
      k_d     = k_q;
      i_d     = i_q;
      j_d     = j_q;
      kk_d    = kk_q;
      a_d     = a_q;
      b_d     = b_q;
      row_d   = row_q;
      err_d   = err_q;
      drain_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d   = m_dim;
               n_d   = n_dim;
               k_d   = k_dim;
               i_d   = '0;
               j_d   = '0;
               kk_d  = '0;
               a_d   = '0;
               b_d   = '0;
               row_d = '0;
               err_d = !dims_ok;
            end
         end
         RUN: begin
            a_d  = a_q + AONE;
            b_d  = b_q + AW'(n_q);
            kk_d = last_k ? '0 : kk_q + ONE;
         end
         DRAIN: drain_d = !drain_q;
         WB: begin
            if (wb_ready) begin
               if (last_j) begin
                  j_d   = '0;
                  i_d   = i_q + ONE;
                  row_d = row_q + AW'(k_q);
                  a_d   = row_q + AW'(k_q);
                  b_d   = '0;
               end else begin
                  j_d = j_q + ONE;
                  a_d = row_q;
                  b_d = AW'(j_q + ONE);
               end
            end
         end
         default: drain_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_q     <= '0;
         n_q     <= '0;
         k_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         kk_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         row_q   <= '0;
         err_q   <= 1'b0;
         drain_q <= 1'b0;
         mult_q  <= 1'b0;
         acc_q   <= 1'b0;
      end else begin
         m_q     <= m_d;
         n_q     <= n_d;
         k_q     <= k_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kk_q    <= kk_d;
         a_q     <= a_d;
         b_q     <= b_d;
         row_q   <= row_d;
         err_q   <= err_d;
         drain_q <= drain_d;
         mult_q  <= load_en;
         acc_q   <= mult_q;
      end
   end

   assign a_addr  = a_q;
   assign b_addr  = b_q;
   assign mult_en = mult_q;
   assign acc_en  = acc_q;
   assign wb_row  = i_q;
   assign wb_col  = j_q;

`ifdef PERF_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset)                         cnt_q <= '0;
      else if (state_q == IDLE && start) cnt_q <= '0;
      else if (busy)                     cnt_q <= cnt_q + 32'd1;
   end

   assign cycle_count = cnt_q;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed, table-driven bench for matmul_sequencer with hand-computed cycle/address expectations.
module tb_matmul_sequencer;
   localparam int DW = 4;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset, start, wb_ready;
   logic [DW-1:0] m_dim, n_dim, k_dim;
   logic          busy, load_en, mult_en, acc_en, acc_clr, wb_valid, done, err;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] wb_row, wb_col;
   logic [31:0]   cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int m, n, k, stall, restart, exp_done, exp_err, exp_first_wb;
   } vec_t;

   vec_t vecs[10];

   matmul_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim),
      .busy(busy), .a_addr(a_addr), .b_addr(b_addr),
      .load_en(load_en), .mult_en(mult_en), .acc_en(acc_en), .acc_clr(acc_clr),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_row(wb_row), .wb_col(wb_col),
      .done(done), .err(err), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " load_en"}, load_en, 0);
      check({tag, " mult_en"}, mult_en, 0);
      check({tag, " acc_en"}, acc_en, 0);
      check({tag, " acc_clr"}, acc_clr, 0);
      check({tag, " wb_valid"}, wb_valid, 0);
      check({tag, " done"}, done, 0);
      check({tag, " err"}, err, 0);
      check({tag, " a_addr"}, a_addr, 0);
      check({tag, " b_addr"}, b_addr, 0);
      check({tag, " wb_row"}, wb_row, 0);
      check({tag, " wb_col"}, wb_col, 0);
      check({tag, " cycle_count"}, cycle_count, 0);
   endtask

   // Start in cycle 0 (the negedge before the sampling edge); cycle c is sampled at the following negedges.
   task automatic run_cmd(input vec_t v);
      int  loads = 0, mults = 0, accs = 0, clrs = 0, wbv = 0, wbs = 0;
      int  first_load = 0, first_wb = 0, done_cyc = 0, kk = 0, ei = 0, ej = 0, stalls = 0;
      int  exp_wb, exp_loads, exp_wbv, exp_cnt;
      bit  legal, seen_done = 0;
      logic got_err = 1'b0, pl1 = 1'b0, pl2 = 1'b0;

      legal     = (v.m >= 1 && v.m <= 8 && v.n >= 1 && v.n <= 8 && v.k >= 1 && v.k <= 8);
      exp_wb    = legal ? v.m * v.n : 0;
      exp_loads = legal ? v.m * v.n * v.k : 0;
      exp_wbv   = legal ? exp_wb + v.stall : 0;
`ifdef PERF_CNT_EN
      exp_cnt = v.exp_done;
`else
      exp_cnt = 0;
`endif

      @(negedge clk);
      start = 1'b1;
      m_dim = v.m[DW-1:0];
      n_dim = v.n[DW-1:0];
      k_dim = v.k[DW-1:0];
      wb_ready = 1'b1;
      for (int c = 1; c <= 1000 && !seen_done; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (v.restart != 0 && c >= 2 && c <= 5) begin
            start = 1'b1;
            m_dim = 4'd3;
            n_dim = 4'd3;
            k_dim = 4'd3;
         end
         check("busy", busy, 1);
         check("mult_en pipe", mult_en, pl1);
         check("acc_en pipe", acc_en, pl2);
         pl2 = pl1;
         pl1 = load_en;
         check("acc_clr", acc_clr, load_en && kk == 0);
         if (!done) check("err without done", err, 0);
         clrs  += acc_clr;
         mults += mult_en;
         accs  += acc_en;
         if (load_en) begin
            loads++;
            if (first_load == 0) first_load = c;
            check("a_addr", a_addr, ei * v.k + kk);
            check("b_addr", b_addr, kk * v.n + ej);
            kk++;
         end
         if (wb_valid) begin
            wbv++;
            if (first_wb == 0) first_wb = c;
            check("wb_row", wb_row, ei);
            check("wb_col", wb_col, ej);
            if (stalls < v.stall) begin
               wb_ready = 1'b0;
               stalls++;
            end else begin
               wb_ready = 1'b1;
               wbs++;
               kk = 0;
               ej++;
               if (ej == v.n) begin
                  ej = 0;
                  ei++;
               end
            end
         end else begin
            wb_ready = 1'b1;
         end
         if (done) begin
            seen_done = 1;
            done_cyc  = c;
            got_err   = err;
         end
      end
      start = 1'b0;
      wb_ready = 1'b1;
      if (!seen_done) check("done timeout", 0, 1);
      check("done cycle", done_cyc, v.exp_done);
      check("err flag", got_err, v.exp_err);
      check("writebacks", wbs, exp_wb);
      check("wb_valid cycles", wbv, exp_wbv);
      check("load_en count", loads, exp_loads);
      check("mult_en count", mults, exp_loads);
      check("acc_en count", accs, exp_loads);
      check("acc_clr count", clrs, exp_wb);
      check("first load cycle", first_load, legal ? 1 : 0);
      check("first wb cycle", first_wb, v.exp_first_wb);
      @(negedge clk);
      check("busy after done", busy, 0);
      check("done pulse width", done, 0);
      check("cycle_count after done", cycle_count, exp_cnt);
   endtask

   initial begin
      //           m  n  k  stall restart done err first_wb
      vecs[0] = '{1, 1, 1, 0, 0,   5, 0,  4};
      vecs[1] = '{2, 2, 2, 0, 0,  21, 0,  5};
      vecs[2] = '{1, 1, 4, 3, 0,  11, 0,  7};
      vecs[3] = '{2, 2, 0, 0, 0,   1, 1,  0};
      vecs[4] = '{9, 1, 1, 0, 0,   1, 1,  0};
      vecs[5] = '{3, 2, 1, 0, 0,  25, 0,  4};
      vecs[6] = '{8, 8, 8, 0, 0, 705, 0, 11};
      vecs[7] = '{1, 3, 2, 2, 0,  18, 0,  5};
      vecs[8] = '{1, 2, 1, 0, 1,   9, 0,  4};
      vecs[9] = '{0, 1, 1, 0, 0,   1, 1,  0};

      reset    = 1'b1;
      start    = 1'b0;
      wb_ready = 1'b1;
      m_dim    = '0;
      n_dim    = '0;
      k_dim    = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      for (int v = 0; v < 10; v++) run_cmd(vecs[v]);

      // Reset in the middle of a 3x3x3 run, then a clean 1x1x1 command.
      @(negedge clk);
      start = 1'b1;
      m_dim = 4'd3;
      n_dim = 4'd3;
      k_dim = 4'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre-reset load_en", load_en, 1);
      reset = 1'b1;
      @(negedge clk);
      check_zero("mid-run reset");
      reset = 1'b0;
      run_cmd(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
